// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: requester, BRAM-pin and status signals of the BRAM port arbiter
// slave: arbiter side (r0_*/r1_* requests in, grants/read returns out, mem_* pins, lock_err)
// master: requester/memory side, the mirror of slave
interface bram_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, lock_err;
  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata, mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_wdata, mem_we, lock_err
  );
  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_lock, r1_addr, r1_wdata, mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_wdata, mem_we, lock_err
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter with lock and timeout sharing one BRAM port between two requesters
// clk: clock; reset: asynchronous active-low reset
// bus (slave): r0_*/r1_* request beats in, gnt/rvalid/rdata out; mem_* BRAM port pins; lock_err timeout pulse
module bram_port_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int LOCK_TMO = 16
) (
  input logic                clk,
  input logic                reset,
  bram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [7:0]        idle_q, idle_d;
  logic              lock_err_q, lock_err_d;
  logic [RD_LAT-1:0] pv_q, pid_q;
  logic              g0, g1, rd, own_idle, tmo;
  // last_q holds the id of the last granted requester; the other one wins a tie
  assign g0 = reset & bus.r0_req & ((state_q == OWN0) | ((state_q == IDLE) & (!bus.r1_req | last_q)));
  assign g1 = reset & bus.r1_req & ((state_q == OWN1) | ((state_q == IDLE) & (!bus.r0_req | !last_q)));
  assign rd = (g0 & !bus.r0_we) | (g1 & !bus.r1_we);
  assign own_idle = ((state_q == OWN0) & !bus.r0_req) | ((state_q == OWN1) & !bus.r1_req);
  assign tmo = own_idle & (idle_q == 8'(LOCK_TMO - 1));
  always_comb begin
    state_d    = g0 ? (bus.r0_lock ? OWN0 : IDLE) : g1 ? (bus.r1_lock ? OWN1 : IDLE) : tmo ? IDLE : state_q;
    last_d     = g1 ? 1'b1 : g0 ? 1'b0 : last_q;
    idle_d     = (g0 | g1 | tmo) ? 8'd0 : own_idle ? idle_q + 8'd1 : idle_q;
    lock_err_d = tmo;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      idle_q     <= 8'd0;
      lock_err_q <= 1'b0;
      pv_q       <= '0;
      pid_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idle_q     <= idle_d;
      lock_err_q <= lock_err_d;
      // shift toward the MSB; bit RD_LAT-1 is the tail, valid RD_LAT cycles after the grant
      pv_q       <= RD_LAT'({pv_q, rd});
      pid_q      <= RD_LAT'({pid_q, g1});
    end
  end
  assign bus.r0_gnt    = g0;
  assign bus.r1_gnt    = g1;
  assign bus.mem_we    = (g0 & bus.r0_we) | (g1 & bus.r1_we);
  assign bus.mem_addr  = g0 ? bus.r0_addr : g1 ? bus.r1_addr : {ADDR_W{1'b0}};
  assign bus.mem_wdata = g0 ? bus.r0_wdata : g1 ? bus.r1_wdata : {DATA_W{1'b0}};
  assign bus.r0_rvalid = pv_q[RD_LAT-1] & !pid_q[RD_LAT-1];
  assign bus.r1_rvalid = pv_q[RD_LAT-1] & pid_q[RD_LAT-1];
  assign bus.r0_rdata  = bus.mem_rdata;
  assign bus.r1_rdata  = bus.mem_rdata;
  assign bus.lock_err  = lock_err_q;
endmodule
